pipelined_add_sub: RTL and testbench
====================================

// Module: pipelined_add_sub
// PURPOSE
//   Parametrised multi-cycle adder/subtractor, the successor to the 1-bit half-adder cells.
//   Splits a WIDTH-bit add/sub into STAGES registered carry-chained slices with valid/ready flow control.
//   Sits between an operand producer and a result consumer; used wherever a wide add would miss timing.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; must be >= 2.
//   STAGES  2   pipeline depth = latency in cycles; WIDTH % STAGES == 0 required (elaboration $error otherwise).
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active low
//   in_valid   in   1      operand beat present
//   in_ready   out  1      block accepts a beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry in
//   sub        in   1      0: A+B+cin; 1: A+~B+(cin^1), i.e. A-B-cin
//   out_valid  out  1      result beat present
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      raw carry out of MSB; in sub mode 1 = no borrow
//   overflow   out  1      two's-complement signed overflow of the operation
// BEHAVIOUR
//   - Slice width C = WIDTH/STAGES. Stage k adds bits [k*C +: C] of A and the effective B, using stage k-1's carry.
//     Stage 0 uses cin^sub as its carry.
//   - Effective B = sub ? ~b : b, formed at input registration.
//   - Upper unprocessed operand bits and lower finished sum bits are carried forward with each beat.
//   - overflow = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]); computed in the last stage.
//   - Latency is exactly STAGES cycles from in_valid&&in_ready to out_valid when the consumer never stalls.
//     Throughput is 1 beat/cycle.
//   - Handshake: a transfer occurs on a cycle where valid && ready. out_valid/sum/cout/overflow hold stable
//     while out_valid && !out_ready.
//   - Per-stage valid bit v[k]. Stage k loads when !v[k] || advance[k].
//     advance[last] = out_ready; advance[k] = v[k] && (!v[k+1] || advance[k+1]).
//     in_ready = !v[0] || advance[0]. in_ready depends combinationally on out_ready.
//   - Pipeline full (all v set) with out_ready=0: in_ready=0, no state changes.
//   - Full with out_ready=1: the whole pipe shifts and a new beat is accepted in the same cycle.
//   - Bubbles collapse: an empty stage accepts data even while downstream is stalled.
//   - in_valid with in_ready=0 is ignored; the producer holds the beat.
//   - Beats never reorder, duplicate or drop.
//   - Reset (rst_n low at a clk edge): all v=0, out_valid=0, sum=0, cout=0, overflow=0, all data registers 0.
//     In-flight beats are discarded; in_ready=1 from the first cycle after reset.
//     rst_n low has priority over every handshake in that cycle.
//   - Wrap-around: sum wraps modulo 2^WIDTH. No saturation.
// TESTING (WIDTH=8, STAGES=2 unless noted)
//   1. Reset: hold rst_n=0 for 2 cycles -> out_valid=0, sum=8'h00, cout=0, overflow=0, in_ready=1.
//   2. Add wrap: a=FF b=01 cin=0 sub=0 -> 2 cycles later sum=00 cout=1 ovf=0.
//      a=7F b=01 -> sum=80 cout=0 ovf=1.
//   3. Subtract: a=80 b=01 sub=1 cin=0 -> sum=7F cout=1 ovf=1.
//      a=05 b=07 sub=1 -> sum=FE cout=0 ovf=0.
//      a=05 b=02 sub=1 cin=1 -> sum=02.
//   4. Stream: 16 back-to-back beats, out_ready=1 -> 16 results on consecutive cycles, first at +2, in order.
//   5. Backpressure: out_ready=0 while feeding -> in_ready drops after 2 accepted beats, sum held stable.
//      Release -> all beats exit in order, no loss.
//   6. Reset mid-flight: 2 beats in pipe, rst_n=0 for 1 cycle -> out_valid=0 next cycle, neither beat emerges.
//      Then run 1000 random beats with random out_ready vs a reference model; repeat for WIDTH=32 STAGES=4.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// Multi-cycle adder/subtractor: the WIDTH-bit add is split into STAGES carry-chained registered
// slices with per-stage valid bits and collapsing-bubble valid/ready flow control.
module pipelined_add_sub #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int unsigned C    = WIDTH / STAGES;
    localparam int unsigned Last = STAGES - 1;

    if (WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_add_sub: WIDTH must be >= 2 and a multiple of STAGES");
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] vin;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [STAGES-1:0] c_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nx;
    logic [C:0]        slice;
    logic              ovf_nx;

    // A stage advances when it holds a beat and the next stage is empty or advancing itself.
    always_comb begin
        adv       = '0;
        adv[Last] = out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            adv[k] = v_q[k] && (!v_q[k+1] || adv[k+1]);
        end
        ld     = ~v_q | adv;
        vin    = '0;
        vin[0] = in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            vin[k] = v_q[k-1];
        end
    end

    always_comb begin
        slice = '0;
        c_in  = '0;
        c_nx  = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            if (k == 0) begin
                a_in[k] = a;
                b_in[k] = sub ? ~b : b;
                s_in[k] = '0;
                c_in[k] = cin ^ sub;
            end else begin
                a_in[k] = a_q[k-1];
                b_in[k] = b_q[k-1];
                s_in[k] = s_q[k-1];
                c_in[k] = c_q[k-1];
            end
            slice = {1'b0, a_in[k][k*C +: C]} + {1'b0, b_in[k][k*C +: C]} + {{C{1'b0}}, c_in[k]};
            s_nx[k]            = s_in[k];
            s_nx[k][k*C +: C]  = slice[C-1:0];
            c_nx[k]            = slice[C];
        end
        ovf_nx = (a_in[Last][WIDTH-1] == b_in[Last][WIDTH-1]) &&
                 (s_nx[Last][WIDTH-1] != a_in[Last][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (ld[k]) begin
                    v_q[k] <= vin[k];
                    if (vin[k]) begin
                        a_q[k] <= a_in[k];
                        b_q[k] <= b_in[k];
                        s_q[k] <= s_nx[k];
                        c_q[k] <= c_nx[k];
                    end
                end
            end
            if (ld[Last] && vin[Last]) begin
                ovf_q <= ovf_nx;
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[Last];
    assign sum       = s_q[Last];
    assign cout      = c_q[Last];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed cases on an 8/2 instance, random traffic on 8/2 and 32/4,
// all results scored against a full-width arithmetic model.
module tb_pipelined_add_sub;
    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv    [2];
    logic        orr   [2];
    logic        cin_s [2];
    logic        sub_s [2];
    logic [31:0] a_s   [2];
    logic [31:0] b_s   [2];

    logic        ir8, ov8, co8, of8;
    logic [7:0]  sum8;
    logic        ir32, ov32, co32, of32;
    logic [31:0] sum32;

    logic        ir_w  [2];
    logic        ov_w  [2];
    logic        co_w  [2];
    logic        of_w  [2];
    logic [31:0] sum_w [2];

    always_comb begin
        ir_w[0] = ir8;   ov_w[0] = ov8;   co_w[0] = co8;   of_w[0] = of8;   sum_w[0] = {24'h0, sum8};
        ir_w[1] = ir32;  ov_w[1] = ov32;  co_w[1] = co32;  of_w[1] = of32;  sum_w[1] = sum32;
    end

    pipelined_add_sub #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir8),
        .a(a_s[0][7:0]), .b(b_s[0][7:0]), .cin(cin_s[0]), .sub(sub_s[0]),
        .out_valid(ov8), .out_ready(orr[0]), .sum(sum8), .cout(co8), .overflow(of8)
    );

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir32),
        .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]), .sub(sub_s[1]),
        .out_valid(ov32), .out_ready(orr[1]), .sum(sum32), .cout(co32), .overflow(of32)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   recv [2] = '{0, 0};
    bit   lat_chk  = 1'b0;
    exp_t q0 [$];
    exp_t q1 [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input int id);
        return (id == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    // Reference: one full-width add, no slicing.
    function automatic void ref_calc(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic ci, input logic sb, output logic [31:0] s,
                                     output logic c, output logic o);
        logic [63:0] mask, beff, t;
        mask = (64'd1 << w) - 64'd1;
        beff = sb ? (~{32'h0, b}) & mask : {32'h0, b};
        t    = {32'h0, a} + beff + {63'h0, ci ^ sb};
        s    = t[31:0] & mask[31:0];
        c    = t[w];
        o    = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
    endfunction

    exp_t        m_e;
    bit          m_have;
    bit          hold_prev [2] = '{0, 0};
    logic [31:0] prev_sum  [2];
    logic        prev_co   [2];
    logic        prev_of   [2];

    always @(negedge clk) begin
        for (int id = 0; id < 2; id++) begin
            if (!rst_n) begin
                if (id == 0) q0.delete(); else q1.delete();
                hold_prev[id] = 1'b0;
            end else begin
                if (hold_prev[id]) begin
                    chk($sformatf("hold_valid%0d", id), {31'h0, ov_w[id]}, 32'd1);
                    chk($sformatf("hold_sum%0d", id), sum_w[id], prev_sum[id]);
                    chk($sformatf("hold_flags%0d", id), {30'h0, co_w[id], of_w[id]},
                        {30'h0, prev_co[id], prev_of[id]});
                end
                if (ov_w[id] && orr[id]) begin
                    m_have = 1'b0;
                    if (id == 0 && q0.size() > 0) begin m_e = q0.pop_front(); m_have = 1'b1; end
                    if (id == 1 && q1.size() > 0) begin m_e = q1.pop_front(); m_have = 1'b1; end
                    if (!m_have) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output%0d: got sum %h expected no beat", id, sum_w[id]);
                    end else begin
                        recv[id]++;
                        chk($sformatf("sum%0d", id), sum_w[id], m_e.s);
                        chk($sformatf("cout%0d", id), {31'h0, co_w[id]}, {31'h0, m_e.c});
                        chk($sformatf("ovf%0d", id), {31'h0, of_w[id]}, {31'h0, m_e.o});
                        if (lat_chk && id == 0) chk("latency", cyc - m_e.cyc, 32'd2);
                    end
                end
                if (iv[id] && ir_w[id]) begin
                    ref_calc((id == 0) ? 8 : 32, a_s[id], b_s[id], cin_s[id], sub_s[id],
                             m_e.s, m_e.c, m_e.o);
                    m_e.cyc = cyc;
                    if (id == 0) q0.push_back(m_e); else q1.push_back(m_e);
                end
                hold_prev[id] = ov_w[id] && !orr[id];
                prev_sum[id]  = sum_w[id];
                prev_co[id]   = co_w[id];
                prev_of[id]   = of_w[id];
            end
        end
    end

    task automatic set_beat(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic sb);
        a_s[id] = a & wmask(id);
        b_s[id] = b & wmask(id);
        cin_s[id] = ci;
        sub_s[id] = sb;
    endtask

    task automatic rand_beat(input int id);
        set_beat(id, $urandom, $urandom, 1'($urandom), 1'($urandom));
    endtask

    task automatic wait_drain(input int id, input string name);
        int n;
        iv[id]  = 1'b0;
        orr[id] = 1'b1;
        n = (id == 0) ? q0.size() : q1.size();
        for (int i = 0; i < 100 && n != 0; i++) begin
            @(posedge clk); #1;
            n = (id == 0) ? q0.size() : q1.size();
        end
        chk(name, n, 0);
    endtask

    task automatic send8(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb, input logic [7:0] es,
                         input logic ec, input logic eo);
        bit got;
        got = 1'b0;
        orr[0] = 1'b1;
        set_beat(0, {24'h0, a}, {24'h0, b}, ci, sb);
        iv[0] = 1'b1;
        @(negedge clk);
        chk({name, "_ready"}, {31'h0, ir8}, 32'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ov8) begin
                got = 1'b1;
                chk({name, "_lat"}, i, 1);
                chk({name, "_sum"}, {24'h0, sum8}, {24'h0, es});
                chk({name, "_cout"}, {31'h0, co8}, {31'h0, ec});
                chk({name, "_ovf"}, {31'h0, of8}, {31'h0, eo});
            end
        end
        if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ms;
        logic        mc, mo;
        int          nacc, start, seen, cycles;
        int          sent [2];
        int          base [2];
        bit          acc  [2];

        for (int id = 0; id < 2; id++) begin
            iv[id] = 1'b0; orr[id] = 1'b1;
            set_beat(id, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int id = 0; id < 2; id++) begin
            chk($sformatf("rst_valid%0d", id), {31'h0, ov_w[id]}, 32'd0);
            chk($sformatf("rst_sum%0d", id), sum_w[id], 32'd0);
            chk($sformatf("rst_flags%0d", id), {30'h0, co_w[id], of_w[id]}, 32'd0);
            chk($sformatf("rst_ready%0d", id), {31'h0, ir_w[id]}, 32'd1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        ref_calc(8, 32'h80, 32'h01, 1'b0, 1'b1, ms, mc, mo);
        chk("model_sub8", {ms[29:0], mc, mo}, {30'h7F, 1'b1, 1'b1});
        ref_calc(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, ms, mc, mo);
        chk("model_add32", ms, 32'h0);
        chk("model_add32_c", {30'h0, mc, mo}, {30'h0, 1'b1, 1'b0});

        send8("add_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send8("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send8("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        send8("sub_neg",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        send8("sub_borin", 8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);

        // Back-to-back stream with no stalls.
        lat_chk = 1'b1;
        start = recv[0];
        orr[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_beat(0);
            iv[0] = 1'b1;
            @(negedge clk);
            chk("stream_ready", {31'h0, ir8}, 32'd1);
            @(posedge clk); #1;
        end
        wait_drain(0, "stream_drain");
        chk("stream_count", recv[0] - start, 16);
        lat_chk = 1'b0;

        // Backpressure: the pipe fills with exactly STAGES beats.
        orr[0] = 1'b0;
        nacc = 0;
        rand_beat(0);
        iv[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc[0] = ir8;
            if (acc[0]) nacc++;
            @(posedge clk); #1;
            if (acc[0]) rand_beat(0);
        end
        chk("bp_accepted", nacc, 2);
        @(negedge clk);
        chk("bp_ready_low", {31'h0, ir8}, 32'd0);
        @(posedge clk); #1;
        start = recv[0];
        wait_drain(0, "bp_drain");
        chk("bp_count", recv[0] - start, 2);

        // Reset with two beats in flight.
        orr[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_beat(0);
            iv[0] = 1'b1;
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", {31'h0, ov8}, 32'd0);
        chk("midrst_ready", {31'h0, ir8}, 32'd1);
        orr[0] = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov8) seen++;
        end
        chk("midrst_no_emerge", seen, 0);

        // Random traffic on both instances concurrently.
        for (int id = 0; id < 2; id++) begin
            sent[id] = 0; base[id] = recv[id]; iv[id] = 1'b0;
        end
        cycles = 0;
        while ((sent[0] < 1000 || sent[1] < 1000) && cycles < 20000) begin
            @(negedge clk);
            for (int id = 0; id < 2; id++) acc[id] = iv[id] && ir_w[id];
            @(posedge clk); #1;
            cycles++;
            for (int id = 0; id < 2; id++) begin
                if (acc[id]) sent[id]++;
                if (!iv[id] || acc[id]) begin
                    if (sent[id] < 1000 && $urandom_range(3) != 0) begin
                        rand_beat(id);
                        iv[id] = 1'b1;
                    end else begin
                        iv[id] = 1'b0;
                    end
                end
                orr[id] = ($urandom_range(3) != 0);
            end
        end
        chk("random_budget", {31'h0, cycles < 20000}, 32'd1);
        wait_drain(0, "random_drain8");
        wait_drain(1, "random_drain32");
        chk("random_count8", recv[0] - base[0], sent[0]);
        chk("random_count32", recv[1] - base[1], sent[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
